// File: rtl/sys_ctrl_burst_if.sv
// Bus bundle between the UART command controller and its RX/TX, register-file and ALU neighbours.
interface sys_ctrl_burst_if #(
   parameter int DATA_W = 8,
   parameter int ALU_W  = 16,
   parameter int FUNC_W = 4,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] RX_P_DATA;
   logic              RX_D_VLD;
   logic [DATA_W-1:0] RdData;
   logic              RdData_Valid;
   logic [ALU_W-1:0]  ALU_OUT;
   logic              OUT_Valid;
   logic              FIFO_FULL;
   logic [ADDR_W-1:0] Address;
   logic              WrEn;
   logic              RdEn;
   logic [DATA_W-1:0] WrData;
   logic [FUNC_W-1:0] ALU_FUN;
   logic              ALU_EN;
   logic              CLK_EN;
   logic [DATA_W-1:0] TX_P_DATA;
   logic              TX_D_VLD;
   logic              clk_div_en;
   logic              err_pulse;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
      output Address, WrEn, RdEn, WrData, ALU_FUN, ALU_EN, CLK_EN,
             TX_P_DATA, TX_D_VLD, clk_div_en, err_pulse
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
      input  Address, WrEn, RdEn, WrData, ALU_FUN, ALU_EN, CLK_EN,
             TX_P_DATA, TX_D_VLD, clk_div_en, err_pulse
   );
endinterface

// File: rtl/sys_ctrl_burst.sv
// UART command controller: decodes byte-framed commands, drives the register file and ALU,
// streams read data / ALU results / NACK bytes to the TX FIFO, aborts on inter-byte timeout.
module sys_ctrl_burst #(
   parameter int              DATA_W   = 8,
   parameter int              ALU_W    = 16,
   parameter int              FUNC_W   = 4,
   parameter int              ADDR_W   = 4,
   parameter int              TMO_CYC  = 1023,
   parameter logic [DATA_W-1:0] NACK_VAL = DATA_W'(8'hFF)
) (
   input  logic            CLK,
   input  logic            RST,
   sys_ctrl_burst_if.master bus
);
   localparam int NBYTES   = ALU_W / DATA_W;
   localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TMO_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
   localparam int TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

   localparam logic [DATA_W-1:0] CMD_WR    = DATA_W'(8'hAA);
   localparam logic [DATA_W-1:0] CMD_RD    = DATA_W'(8'hBB);
   localparam logic [DATA_W-1:0] CMD_OPS   = DATA_W'(8'hCC);
   localparam logic [DATA_W-1:0] CMD_EXEC  = DATA_W'(8'hDD);
   localparam logic [DATA_W-1:0] CMD_BURST = DATA_W'(8'hEE);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, RD_REQ, RD_WAIT, RD_TX,
      OP_A, OP_B, ALU_FUNC, ALU_WAIT, ALU_TX, NACK
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [FUNC_W-1:0] func_reg;
   logic [DATA_W-1:0] cnt_reg;
   logic [DATA_W-1:0] data_reg;
   logic [ALU_W-1:0]  alu_reg;
   logic [IDX_W-1:0]  byte_idx_reg;
   logic [TMO_W-1:0]  tmo_reg;
   logic              burst_reg;
   logic              alu_en_reg;

   logic              rx_vld;
   logic [DATA_W-1:0] rx_byte;
   logic              awaiting;
   logic              tmo_hit;
   logic              tx_push;
   logic              last_byte;
   logic [DATA_W-1:0] alu_bytes [NBYTES];

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_alu_bytes
         assign alu_bytes[gi] = alu_reg[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign rx_vld    = bus.RX_D_VLD;
   assign rx_byte   = bus.RX_P_DATA;
   assign awaiting  = (state_reg inside {WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, OP_A, OP_B, ALU_FUNC});
   assign tmo_hit   = (TMO_CYC != 0) && awaiting && !rx_vld && (tmo_reg == TMO_W'(TMO_LAST));
   assign tx_push   = (state_reg inside {RD_TX, ALU_TX, NACK}) && !bus.FIFO_FULL;
   assign last_byte = (byte_idx_reg == IDX_W'(NBYTES - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (tmo_hit) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: if (rx_vld) begin
               if      (rx_byte == CMD_WR)                         state_next = WR_ADDR;
               else if (rx_byte == CMD_RD || rx_byte == CMD_BURST) state_next = RD_ADDR;
               else if (rx_byte == CMD_OPS)                        state_next = OP_A;
               else if (rx_byte == CMD_EXEC)                       state_next = ALU_FUNC;
               else                                                state_next = NACK;
            end
            WR_ADDR:  if (rx_vld) state_next = WR_DATA;
            WR_DATA:  if (rx_vld) state_next = IDLE;
            RD_ADDR:  if (rx_vld) state_next = burst_reg ? RD_CNT : RD_REQ;
            RD_CNT:   if (rx_vld) state_next = (rx_byte == '0) ? NACK : RD_REQ;
            RD_REQ:   state_next = RD_WAIT;
            RD_WAIT:  if (bus.RdData_Valid) state_next = RD_TX;
            RD_TX:    if (tx_push) state_next = (cnt_reg == DATA_W'(1)) ? IDLE : RD_REQ;
            OP_A:     if (rx_vld) state_next = OP_B;
            OP_B:     if (rx_vld) state_next = ALU_FUNC;
            ALU_FUNC: if (rx_vld) state_next = ALU_WAIT;
            ALU_WAIT: if (bus.OUT_Valid) state_next = ALU_TX;
            ALU_TX:   if (tx_push && last_byte) state_next = IDLE;
            NACK:     if (tx_push) state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         addr_reg     <= '0;
         func_reg     <= '0;
         cnt_reg      <= '0;
         data_reg     <= '0;
         alu_reg      <= '0;
         byte_idx_reg <= '0;
         tmo_reg      <= '0;
         burst_reg    <= 1'b0;
         alu_en_reg   <= 1'b0;
      end else begin
         tmo_reg    <= (awaiting && !rx_vld && !tmo_hit) ? tmo_reg + TMO_W'(1) : '0;
         alu_en_reg <= (state_reg == ALU_FUNC) && rx_vld;
         case (state_reg)
            IDLE:     if (rx_vld) burst_reg <= (rx_byte == CMD_BURST);
            WR_ADDR:  if (rx_vld) addr_reg <= rx_byte[ADDR_W-1:0];
            RD_ADDR:  if (rx_vld) begin
               addr_reg <= rx_byte[ADDR_W-1:0];
               cnt_reg  <= DATA_W'(1);
            end
            RD_CNT:   if (rx_vld) cnt_reg <= rx_byte;
            RD_WAIT:  if (bus.RdData_Valid) data_reg <= bus.RdData;
            // address wraps naturally at 2^ADDR_W
            RD_TX:    if (tx_push) begin
               cnt_reg  <= cnt_reg - DATA_W'(1);
               addr_reg <= addr_reg + ADDR_W'(1);
            end
            ALU_FUNC: if (rx_vld) func_reg <= rx_byte[FUNC_W-1:0];
            ALU_WAIT: if (bus.OUT_Valid) begin
               alu_reg      <= bus.ALU_OUT;
               byte_idx_reg <= '0;
            end
            ALU_TX:   if (tx_push) byte_idx_reg <= byte_idx_reg + IDX_W'(1);
            default: ;
         endcase
      end
   end

   // Outputs are decoded from state so an async reset drops every strobe immediately.
   always_comb begin
      bus.Address    = addr_reg;
      bus.WrEn       = 1'b0;
      bus.RdEn       = 1'b0;
      bus.WrData     = '0;
      bus.ALU_FUN    = func_reg;
      bus.ALU_EN     = alu_en_reg;
      bus.CLK_EN     = 1'b0;
      bus.TX_P_DATA  = '0;
      bus.TX_D_VLD   = 1'b0;
      bus.clk_div_en = 1'b1;
      bus.err_pulse  = tmo_hit;
      case (state_reg)
         WR_DATA: begin
            bus.WrEn   = rx_vld;
            bus.WrData = rx_byte;
         end
         OP_A: begin
            bus.Address = '0;
            bus.WrEn    = rx_vld;
            bus.WrData  = rx_byte;
         end
         OP_B: begin
            bus.Address = ADDR_W'(1);
            bus.WrEn    = rx_vld;
            bus.WrData  = rx_byte;
         end
         RD_REQ: bus.RdEn = 1'b1;
         RD_TX: begin
            bus.TX_P_DATA = data_reg;
            bus.TX_D_VLD  = !bus.FIFO_FULL;
         end
         ALU_FUNC, ALU_WAIT: bus.CLK_EN = 1'b1;
         ALU_TX: begin
            bus.CLK_EN    = 1'b1;
            bus.TX_P_DATA = alu_bytes[byte_idx_reg];
            bus.TX_D_VLD  = !bus.FIFO_FULL;
         end
         NACK: begin
            bus.TX_P_DATA = NACK_VAL;
            bus.TX_D_VLD  = !bus.FIFO_FULL;
            bus.err_pulse = !bus.FIFO_FULL;
         end
         default: ;
      endcase
   end
endmodule
